// File: rtl/rsa_wrap_pkg.sv
// Shared types and constants for the RSA stream wrapper.
//   - Avalon bus widths and UART register map / status bit positions
//   - FSM state and load-phase enums
//   - avm_cmd_t: one queued bus transaction (direction, address, tx byte)
package rsa_wrap_pkg;

  localparam int unsigned AVM_ADDR_W = 5;
  localparam int unsigned AVM_DATA_W = 32;

  localparam logic [AVM_ADDR_W-1:0] RX_ADDR   = 5'd0;
  localparam logic [AVM_ADDR_W-1:0] TX_ADDR   = 5'd4;
  localparam logic [AVM_ADDR_W-1:0] STAT_ADDR = 5'd8;

  localparam int unsigned RX_OK_BIT = 7;
  localparam int unsigned TX_OK_BIT = 6;
  localparam int unsigned BRK_BIT   = 5;

  typedef enum logic [2:0] {
    S_POLL_RX,
    S_READ_RX,
    S_START,
    S_WAIT,
    S_POLL_TX,
    S_WRITE
  } state_t;

  typedef enum logic [1:0] {
    LOAD_N,
    LOAD_E,
    LOAD_A
  } phase_t;

  typedef struct packed {
    logic                  rnw;
    logic [AVM_ADDR_W-1:0] addr;
    logic [7:0]            wbyte;
  } avm_cmd_t;

endpackage

// File: rtl/rsa_stream_wrapper_if.sv
// Avalon-MM bus between the wrapper (master) and the UART (slave).
//   address/read/write/writedata : master -> slave
//   readdata/waitrequest         : slave -> master
interface rsa_stream_wrapper_if;
  import rsa_wrap_pkg::*;

  logic [AVM_ADDR_W-1:0] address;
  logic                  read;
  logic [AVM_DATA_W-1:0] readdata;
  logic                  write;
  logic [AVM_DATA_W-1:0] writedata;
  logic                  waitrequest;

  modport master (
    output address, read, write, writedata,
    input  readdata, waitrequest
  );

  modport slave (
    input  address, read, write, writedata,
    output readdata, waitrequest
  );

endinterface

// File: rtl/avm_byte_master.sv
// Single-transaction Avalon-MM engine shared by every bus state.
//   clk, rst_n : clock, synchronous active-low reset
//   req, cmd   : next transaction, taken when the bus is idle or completing
//   done_c     : current transfer completes this cycle (waitrequest low)
//   rdata_c    : low byte of readdata, valid with done_c
//   avm        : Avalon master port
// Out of reset the engine is already polling the status register.
module avm_byte_master
  import rsa_wrap_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req,
  input  avm_cmd_t             cmd,
  output logic                 done_c,
  output logic [7:0]           rdata_c,
  rsa_stream_wrapper_if.master avm
);

  logic active_c;
  logic unused_rdata_hi;

  assign active_c        = avm.read | avm.write;
  assign done_c          = active_c & ~avm.waitrequest;
  assign rdata_c         = avm.readdata[7:0];
  // UART registers are byte wide; upper readdata bits carry nothing.
  assign unused_rdata_hi = ^avm.readdata[AVM_DATA_W-1:8];

  // Request registers only move when idle or on the completing cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      avm.read      <= 1'b1;
      avm.write     <= 1'b0;
      avm.address   <= STAT_ADDR;
      avm.writedata <= '0;
    end else if (!active_c || done_c) begin
      avm.read      <= req & cmd.rnw;
      avm.write     <= req & ~cmd.rnw;
      avm.address   <= req ? cmd.addr : avm.address;
      avm.writedata <= (req && !cmd.rnw) ? AVM_DATA_W'(cmd.wbyte) : '0;
    end
  end

endmodule

// File: rtl/rsa_stream_wrapper.sv
// Polls a UART over Avalon-MM, loads modulus N and exponent E once, then
// streams ciphertext blocks through an external modexp core and returns
// the low OUT_BYTES bytes of each result to the UART, MSB first.
//   avm_clk, avm_rst_n : clock, synchronous active-low reset
//   avm                : Avalon master (UART RX=0, TX=4, STATUS=8)
//   core_start/core_a/core_e/core_n/core_result/core_finished : core handshake
//   key_loaded         : N and E captured
//   busy               : low only while waiting for RX data
//   blocks_done        : completed blocks, wrapping counter
// Optional: RSA_WRAP_REKEY_EN lets a UART break flag seen at a block
// boundary reopen N/E loading; otherwise only reset reloads the key.
// KEY_BITS must be a multiple of 8 and at least 16.
module rsa_stream_wrapper
  import rsa_wrap_pkg::*;
#(
  parameter int unsigned KEY_BITS = 256,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                 avm_clk,
  input  logic                 avm_rst_n,
  rsa_stream_wrapper_if.master avm,
  output logic                 core_start,
  output logic [KEY_BITS-1:0]  core_a,
  output logic [KEY_BITS-1:0]  core_e,
  output logic [KEY_BITS-1:0]  core_n,
  input  logic [KEY_BITS-1:0]  core_result,
  input  logic                 core_finished,
  output logic                 key_loaded,
  output logic                 busy,
  output logic [CNT_W-1:0]     blocks_done
);

  localparam int unsigned KEY_BYTES = KEY_BITS / 8;
  localparam int unsigned OUT_BYTES = KEY_BYTES - 1;
  localparam int unsigned BC_W      = $clog2(KEY_BYTES);
  localparam int unsigned SH_W      = KEY_BITS - 8;

  localparam logic [BC_W-1:0] LAST_IN  = BC_W'(KEY_BYTES - 1);
  localparam logic [BC_W-1:0] LAST_OUT = BC_W'(OUT_BYTES - 1);

  state_t          state;
  phase_t          phase;
  logic [BC_W-1:0] cnt;
  logic [SH_W-1:0] shifter;

  logic       req_c;
  avm_cmd_t   cmd_c;
  logic       done_c;
  logic [7:0] rdata_c;
  logic       last_in_c;
  logic       last_out_c;
  logic       unused_result_top;

  assign last_in_c  = (cnt == LAST_IN);
  assign last_out_c = (cnt == LAST_OUT);
  // The top result byte is never transmitted.
  assign unused_result_top = ^core_result[KEY_BITS-1 -: 8];

  avm_byte_master u_avm (
    .clk     (avm_clk),
    .rst_n   (avm_rst_n),
    .req     (req_c),
    .cmd     (cmd_c),
    .done_c  (done_c),
    .rdata_c (rdata_c),
    .avm     (avm)
  );

  // Look-ahead of the transaction following the current one, so the next
  // request lands on the bus the cycle after completion.
  always_comb begin
    req_c = 1'b0;
    cmd_c = '{rnw: 1'b1, addr: STAT_ADDR, wbyte: 8'h00};
    unique case (state)
      S_POLL_RX: begin
        req_c = done_c;
        if (rdata_c[RX_OK_BIT]) cmd_c.addr = RX_ADDR;
      end
      S_READ_RX: req_c = done_c && !(phase == LOAD_A && last_in_c);
      S_WAIT:    req_c = core_finished;
      S_POLL_TX: begin
        req_c = done_c;
        if (rdata_c[TX_OK_BIT]) begin
          cmd_c.rnw   = 1'b0;
          cmd_c.addr  = TX_ADDR;
          cmd_c.wbyte = shifter[SH_W-1 -: 8];
        end
      end
      S_WRITE:   req_c = done_c;
      default:   req_c = 1'b0;
    endcase
  end

  // Control FSM with registered outputs.
  always_ff @(posedge avm_clk) begin
    if (!avm_rst_n) begin
      state       <= S_POLL_RX;
      phase       <= LOAD_N;
      cnt         <= '0;
      shifter     <= '0;
      core_n      <= '0;
      core_e      <= '0;
      core_a      <= '0;
      core_start  <= 1'b0;
      key_loaded  <= 1'b0;
      busy        <= 1'b0;
      blocks_done <= '0;
    end else begin
      core_start <= 1'b0;
      unique case (state)
        S_POLL_RX: begin
          if (done_c) begin
`ifdef RSA_WRAP_REKEY_EN
            if (rdata_c[BRK_BIT] && phase == LOAD_A && cnt == '0) begin
              phase      <= LOAD_N;
              key_loaded <= 1'b0;
            end
`endif
            if (rdata_c[RX_OK_BIT]) begin
              state <= S_READ_RX;
              busy  <= 1'b1;
            end
          end
        end
        S_READ_RX: begin
          if (done_c) begin
            unique case (phase)
              LOAD_N:  core_n <= {core_n[KEY_BITS-9:0], rdata_c};
              LOAD_E:  core_e <= {core_e[KEY_BITS-9:0], rdata_c};
              default: core_a <= {core_a[KEY_BITS-9:0], rdata_c};
            endcase
            if (last_in_c) begin
              cnt <= '0;
              unique case (phase)
                LOAD_N: begin
                  phase <= LOAD_E;
                  state <= S_POLL_RX;
                  busy  <= 1'b0;
                end
                LOAD_E: begin
                  phase      <= LOAD_A;
                  key_loaded <= 1'b1;
                  state      <= S_POLL_RX;
                  busy       <= 1'b0;
                end
                default: begin
                  state      <= S_START;
                  core_start <= 1'b1;
                end
              endcase
            end else begin
              cnt   <= cnt + 1'b1;
              state <= S_POLL_RX;
              busy  <= 1'b0;
            end
          end
        end
        S_START: state <= S_WAIT;
        S_WAIT: begin
          if (core_finished) begin
            shifter <= core_result[SH_W-1:0];
            cnt     <= '0;
            state   <= S_POLL_TX;
          end
        end
        S_POLL_TX: begin
          if (done_c && rdata_c[TX_OK_BIT]) state <= S_WRITE;
        end
        S_WRITE: begin
          if (done_c) begin
            shifter <= shifter << 8;
            if (last_out_c) begin
              cnt         <= '0;
              blocks_done <= blocks_done + 1'b1;
              phase       <= LOAD_A;
              state       <= S_POLL_RX;
              busy        <= 1'b0;
            end else begin
              cnt   <= cnt + 1'b1;
              state <= S_POLL_TX;
            end
          end
        end
        default: state <= S_POLL_RX;
      endcase
    end
  end

endmodule
